multicycle_sequencer: RTL and testbench

Multi-cycle FSM that sequences the RV datapath around Control_Unit, one instruction per FETCH→DECODE→EXEC→(MEM)→WB pass. A single memory port is shared between instruction fetch and data access. The block issues all datapath enables: PC write, IR write, register write and memory request/write. Control_Unit still supplies the combinational mux selects (ImmSel, ALUSel, WBSel, PCSel…); this block qualifies only the state-changing strobes.

---
 rtl/multicycle_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//   Multi-cycle control sequencer for the RV datapath. Walks each instruction
//   through FETCH -> DECODE -> EXEC -> (MEM) -> WB, shares one memory port
//   between instruction fetch and data access, and issues the state-changing
//   datapath strobes. Mux selects still come from Control_Unit.
//
// Parameters
//   TIMEOUT     max cycles mem_req may wait for mem_ready before trapping (>=2)
//   CNT_W       width of the retired-instruction counter
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   run          1 = keep fetching, 0 = stop at next instruction boundary
//   opcode       6-bit opcode field from IR
//   ctrl_regwen  RegWEn from Control_Unit for the current instruction
//   mem_ready    memory completes the current access this cycle
//   pc_we        PC load strobe
//   ir_we        IR load strobe
//   rf_we        register file write strobe
//   mem_req      memory access request
//   mem_we       memory write (meaningful only with mem_req)
//   addr_sel     memory address mux: 0 = PC, 1 = ALU result
//   state        current FSM state (debug)
//   halted       block is in TRAP
//   trap_cause   00 none, 01 illegal opcode, 10 fetch timeout, 11 data timeout
//   instr_count  retired-instruction count (wraps)
module multicycle_sequencer #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic             ctrl_regwen,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             ir_we,
    output logic             rf_we,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic [2:0]       state,
    output logic             halted,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd7
    } state_t;

    localparam logic [5:0] OP_R      = 6'b011001;
    localparam logic [5:0] OP_I      = 6'b001001;
    localparam logic [5:0] OP_LOAD   = 6'b000001;
    localparam logic [5:0] OP_STORE  = 6'b010001;
    localparam logic [5:0] OP_BRANCH = 6'b110001;
    localparam logic [5:0] OP_LUI    = 6'b011011;
    localparam logic [5:0] OP_JAL    = 6'b110111;

    localparam int unsigned         WAIT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [1:0]         cause_q, cause_d;
    logic [WAIT_W-1:0]  wait_q;
    logic [CNT_W-1:0]   count_q;
    logic               count_inc;

    // Instruction class captured in DECODE so later states do not depend on
    // the opcode input staying meaningful.
    logic               is_load_q, is_store_q, is_branch_q;
    logic               op_legal;

    always_comb begin
        op_legal = (opcode == OP_R)     || (opcode == OP_I)      ||
                   (opcode == OP_LOAD)  || (opcode == OP_STORE)  ||
                   (opcode == OP_BRANCH)|| (opcode == OP_LUI)    ||
                   (opcode == OP_JAL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cause_q     <= 2'b00;
            wait_q      <= '0;
            count_q     <= '0;
            is_load_q   <= 1'b0;
            is_store_q  <= 1'b0;
            is_branch_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            // Clearing on every state change covers entry to FETCH and MEM.
            if (state_d != state_q) begin
                wait_q <= '0;
            end else if (mem_req && !mem_ready) begin
                wait_q <= wait_q + 1'b1;
            end
            if (count_inc) begin
                count_q <= count_q + 1'b1;
            end
            if (state_q == DECODE) begin
                is_load_q   <= (opcode == OP_LOAD);
                is_store_q  <= (opcode == OP_STORE);
                is_branch_q <= (opcode == OP_BRANCH);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        pc_we     = 1'b0;
        ir_we     = 1'b0;
        rf_we     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        halted    = 1'b0;
        count_inc = 1'b0;

        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                mem_req = 1'b1;
                // A late mem_ready on the last wait cycle beats the timeout.
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = TRAP;
                    cause_d = 2'b10;
                end
            end
            DECODE: begin
                if (op_legal) begin
                    state_d = EXEC;
                end else begin
                    state_d = TRAP;
                    cause_d = 2'b01;
                end
            end
            EXEC: begin
                state_d = (is_load_q || is_store_q) ? MEM : WB;
            end
            MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = is_store_q;
                if (mem_ready) begin
                    if (is_store_q) begin
                        // Stores retire straight from MEM; there is no WB.
                        pc_we     = 1'b1;
                        count_inc = 1'b1;
                        state_d   = run ? FETCH : IDLE;
                    end else begin
                        state_d = WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = TRAP;
                    cause_d = 2'b11;
                end
            end
            WB: begin
                rf_we     = ctrl_regwen && !is_store_q && !is_branch_q;
                pc_we     = 1'b1;
                count_inc = 1'b1;
                state_d   = run ? FETCH : IDLE;
            end
            TRAP: begin
                halted = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign state       = state_q;
    assign trap_cause  = cause_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer
//   Directed bench for multicycle_sequencer. Each step drives inputs on the
//   falling edge, pushes the hand-derived expected outputs for that cycle to a
//   scoreboard queue, and pops/compares shortly after.
module tb_multicycle_sequencer;

    localparam int unsigned CW = 3;

    localparam logic [5:0] OP_R      = 6'b011001;
    localparam logic [5:0] OP_I      = 6'b001001;
    localparam logic [5:0] OP_LOAD   = 6'b000001;
    localparam logic [5:0] OP_STORE  = 6'b010001;
    localparam logic [5:0] OP_BRANCH = 6'b110001;
    localparam logic [5:0] OP_LUI    = 6'b011011;
    localparam logic [5:0] OP_BAD    = 6'b111111;

    // Strobe vector order: {ir_we, pc_we, rf_we, mem_req, mem_we, addr_sel, halted}
    localparam logic [6:0] S_NONE  = 7'b0000000;
    localparam logic [6:0] S_FE    = 7'b0001000;
    localparam logic [6:0] S_FEACC = 7'b1001000;
    localparam logic [6:0] S_MEMR  = 7'b0001010;
    localparam logic [6:0] S_MEMW  = 7'b0001110;
    localparam logic [6:0] S_MEMWA = 7'b0101110;
    localparam logic [6:0] S_WBRF  = 7'b0110000;
    localparam logic [6:0] S_WBPC  = 7'b0100000;
    localparam logic [6:0] S_HALT  = 7'b0000001;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run;
    logic [5:0]    opcode;
    logic          ctrl_regwen;
    logic          mem_ready;
    logic          pc_we, ir_we, rf_we, mem_req, mem_we, addr_sel, halted;
    logic [2:0]    state;
    logic [1:0]    trap_cause;
    logic [CW-1:0] instr_count;

    typedef struct {
        string             tag;
        logic [12+CW-1:0]  vec;
    } exp_t;

    exp_t sb_q[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;

    always #5 clk = ~clk;

    multicycle_sequencer #(
        .TIMEOUT(16),
        .CNT_W  (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .opcode     (opcode),
        .ctrl_regwen(ctrl_regwen),
        .mem_ready  (mem_ready),
        .pc_we      (pc_we),
        .ir_we      (ir_we),
        .rf_we      (rf_we),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .addr_sel   (addr_sel),
        .state      (state),
        .halted     (halted),
        .trap_cause (trap_cause),
        .instr_count(instr_count)
    );

    task automatic check_one();
        exp_t             e;
        logic [12+CW-1:0] obs;
        obs = {state, ir_we, pc_we, rf_we, mem_req, mem_we, addr_sel, halted,
               trap_cause, instr_count};
        n_compared++;
        if (sb_q.size() == 0) begin
            n_mismatched++;
            $error("FAIL scoreboard_empty: observed %h required an expected entry", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.vec) else begin
                n_mismatched++;
                $error("FAIL %s: observed st=%0d strobes=%b cause=%b cnt=%0d, expected st=%0d strobes=%b cause=%b cnt=%0d",
                       e.tag, obs[12+CW-1:9+CW], obs[9+CW-1:2+CW], obs[2+CW-1:CW], obs[CW-1:0],
                       e.vec[12+CW-1:9+CW], e.vec[9+CW-1:2+CW], e.vec[2+CW-1:CW], e.vec[CW-1:0]);
            end
        end
    endtask

    task automatic step(input logic rst_i, input logic run_i, input logic rdy_i,
                        input logic [5:0] op_i, input logic rw_i, input string tag,
                        input logic [2:0] st, input logic [6:0] sb,
                        input logic [1:0] cause, input int unsigned cnt);
        exp_t e;
        @(negedge clk);
        rst_n       = rst_i;
        run         = run_i;
        mem_ready   = rdy_i;
        opcode      = op_i;
        ctrl_regwen = rw_i;
        e.tag = tag;
        e.vec = {st, sb, cause, CW'(cnt)};
        sb_q.push_back(e);
        #1;
        check_one();
    endtask

    initial begin
        rst_n       = 1'b0;
        run         = 1'b0;
        mem_ready   = 1'b0;
        opcode      = OP_R;
        ctrl_regwen = 1'b0;

        // Reset state, then async reset in the middle of a fetch
        step(0, 0, 0, OP_R, 0, "reset_state", 0, S_NONE, 0, 0);
        step(1, 1, 0, OP_R, 0, "idle_go", 0, S_NONE, 0, 0);
        step(1, 1, 0, OP_R, 0, "fetch_wait", 1, S_FE, 0, 0);
        step(0, 0, 0, OP_R, 0, "rst_mid_fetch", 0, S_NONE, 0, 0);
        for (int i = 0; i < 10; i++)
            step(1, 0, 1, OP_R, 1, "idle_hold", 0, S_NONE, 0, 0);

        // R-type retire, back-to-back into a load
        step(1, 1, 1, OP_R, 1, "r_idle", 0, S_NONE, 0, 0);
        step(1, 1, 1, OP_R, 1, "r_fetch", 1, S_FEACC, 0, 0);
        step(1, 1, 1, OP_R, 1, "r_decode", 2, S_NONE, 0, 0);
        step(1, 1, 1, OP_R, 1, "r_exec", 3, S_NONE, 0, 0);
        step(1, 1, 1, OP_R, 1, "r_wb", 5, S_WBRF, 0, 0);

        // Load with 3 stall cycles in MEM
        step(1, 1, 1, OP_LOAD, 1, "ld_fetch", 1, S_FEACC, 0, 1);
        step(1, 1, 1, OP_LOAD, 1, "ld_decode", 2, S_NONE, 0, 1);
        step(1, 1, 1, OP_LOAD, 1, "ld_exec", 3, S_NONE, 0, 1);
        for (int i = 0; i < 3; i++)
            step(1, 1, 0, OP_LOAD, 1, "ld_mem_stall", 4, S_MEMR, 0, 1);
        step(1, 1, 1, OP_LOAD, 1, "ld_mem_done", 4, S_MEMR, 0, 1);
        step(1, 1, 1, OP_LOAD, 1, "ld_wb", 5, S_WBRF, 0, 1);

        // Store (one stall) then branch with regwen=1, stop afterwards
        step(1, 1, 1, OP_STORE, 1, "st_fetch", 1, S_FEACC, 0, 2);
        step(1, 1, 1, OP_STORE, 1, "st_decode", 2, S_NONE, 0, 2);
        step(1, 1, 1, OP_STORE, 1, "st_exec", 3, S_NONE, 0, 2);
        step(1, 1, 0, OP_STORE, 1, "st_mem_stall", 4, S_MEMW, 0, 2);
        step(1, 1, 1, OP_STORE, 1, "st_mem_done", 4, S_MEMWA, 0, 2);
        step(1, 1, 1, OP_BRANCH, 1, "br_fetch", 1, S_FEACC, 0, 3);
        step(1, 1, 1, OP_BRANCH, 1, "br_decode", 2, S_NONE, 0, 3);
        step(1, 1, 1, OP_BRANCH, 1, "br_exec", 3, S_NONE, 0, 3);
        step(1, 0, 1, OP_BRANCH, 1, "br_wb", 5, S_WBPC, 0, 3);
        step(1, 0, 1, OP_BRANCH, 1, "br_idle", 0, S_NONE, 0, 4);

        // run dropped mid-instruction: LUI still completes, then stops
        step(1, 1, 1, OP_LUI, 1, "lui_idle", 0, S_NONE, 0, 4);
        step(1, 0, 1, OP_LUI, 1, "lui_fetch", 1, S_FEACC, 0, 4);
        step(1, 0, 1, OP_LUI, 1, "lui_decode", 2, S_NONE, 0, 4);
        step(1, 0, 1, OP_LUI, 1, "lui_exec", 3, S_NONE, 0, 4);
        step(1, 0, 1, OP_LUI, 1, "lui_wb", 5, S_WBRF, 0, 4);
        step(1, 0, 1, OP_LUI, 1, "lui_stopped", 0, S_NONE, 0, 5);

        // Fetch completes on the 16th wait cycle: no trap
        step(1, 1, 0, OP_I, 0, "fto_idle", 0, S_NONE, 0, 5);
        for (int i = 0; i < 15; i++)
            step(1, 1, 0, OP_I, 0, "fto_wait", 1, S_FE, 0, 5);
        step(1, 1, 1, OP_I, 0, "fto_late_ready", 1, S_FEACC, 0, 5);
        step(1, 1, 1, OP_I, 0, "i_decode", 2, S_NONE, 0, 5);
        step(1, 1, 1, OP_I, 0, "i_exec", 3, S_NONE, 0, 5);
        step(1, 1, 0, OP_I, 0, "i_wb_noregwen", 5, S_WBPC, 0, 5);

        // Fetch timeout: mem_ready never comes
        for (int i = 0; i < 16; i++)
            step(1, 1, 0, OP_I, 0, "ftrap_wait", 1, S_FE, 0, 6);
        step(1, 1, 0, OP_I, 0, "ftrap_enter", 7, S_HALT, 2'b10, 6);
        for (int i = 0; i < 3; i++)
            step(1, 1, 1, OP_R, 1, "ftrap_hold", 7, S_HALT, 2'b10, 6);
        step(0, 0, 0, OP_R, 0, "ftrap_reset", 0, S_NONE, 0, 0);

        // Illegal opcode
        step(1, 1, 1, OP_BAD, 1, "ill_idle", 0, S_NONE, 0, 0);
        step(1, 1, 1, OP_BAD, 1, "ill_fetch", 1, S_FEACC, 0, 0);
        step(1, 1, 1, OP_BAD, 1, "ill_decode", 2, S_NONE, 0, 0);
        for (int i = 0; i < 3; i++)
            step(1, 1, 1, OP_BAD, 1, "ill_trap", 7, S_HALT, 2'b01, 0);
        step(0, 0, 0, OP_R, 0, "ill_reset", 0, S_NONE, 0, 0);

        // Data timeout on a load
        step(1, 1, 1, OP_LOAD, 1, "dto_idle", 0, S_NONE, 0, 0);
        step(1, 1, 1, OP_LOAD, 1, "dto_fetch", 1, S_FEACC, 0, 0);
        step(1, 1, 1, OP_LOAD, 1, "dto_decode", 2, S_NONE, 0, 0);
        step(1, 1, 0, OP_LOAD, 1, "dto_exec", 3, S_NONE, 0, 0);
        for (int i = 0; i < 16; i++)
            step(1, 1, 0, OP_LOAD, 1, "dto_wait", 4, S_MEMR, 0, 0);
        step(1, 1, 0, OP_LOAD, 1, "dto_trap", 7, S_HALT, 2'b11, 0);
        step(0, 0, 0, OP_R, 0, "dto_reset", 0, S_NONE, 0, 0);

        // Counter wrap (3-bit counter): nine R-type instructions back to back
        step(1, 1, 1, OP_R, 1, "wrap_idle", 0, S_NONE, 0, 0);
        for (int i = 0; i < 9; i++) begin
            step(1, 1, 1, OP_R, 1, "wrap_fetch", 1, S_FEACC, 0, i % 8);
            step(1, 1, 1, OP_R, 1, "wrap_decode", 2, S_NONE, 0, i % 8);
            step(1, 1, 1, OP_R, 1, "wrap_exec", 3, S_NONE, 0, i % 8);
            step(1, (i < 8) ? 1'b1 : 1'b0, 1, OP_R, 1, "wrap_wb", 5, S_WBRF, 0, i % 8);
        end
        step(1, 0, 1, OP_R, 1, "wrap_count", 0, S_NONE, 0, 9 % 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
